// File: rtl/uart_param_duplex.sv
// -----------------------------------------------------------------------------
// uart_param_duplex
// Parametrised full-duplex UART. The baud divisor, data width, parity mode and
// stop-bit count are set by parameters. TX and RX are independent state
// machines that share one clock. The receiver reports parity and framing
// errors together with each received word.
//
// Optional build macro: UART_LOOPBACK_EN
//   When defined, the module gains a `loopback` input. With loopback=1 the RX
//   synchroniser is fed from the internal TX line and the tx_serial pin is held
//   high. Change loopback only while both FSMs are idle.
//
// Ports:
//   clk            system clock; all logic runs on the rising edge
//   reset          asynchronous reset, active high
//   loopback       (UART_LOOPBACK_EN only) routes TX internally to RX
//   rx_serial      serial receive line; idles high
//   tx_serial      serial transmit line; idles high
//   tx_start       transmit request; sampled only while TX is idle
//   tx_data        word to send; latched when the request is accepted
//   tx_active      high while a frame is on the line
//   tx_done        one-cycle pulse at the end of a frame
//   rx_dv          one-cycle pulse when a received word is valid
//   rx_data        last received word; held until the next rx_dv
//   rx_parity_err  parity mismatch on the last word
//   rx_frame_err   a stop bit of the last word was sampled low
// -----------------------------------------------------------------------------
module uart_param_duplex #(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 reset,
`ifdef UART_LOOPBACK_EN
   input  logic                 loopback,
`endif
   input  logic                 rx_serial,
   output logic                 tx_serial,
   input  logic                 tx_start,
   input  logic [DATA_BITS-1:0] tx_data,
   output logic                 tx_active,
   output logic                 tx_done,
   output logic                 rx_dv,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_parity_err,
   output logic                 rx_frame_err
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BIT_END   = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] MID_END   = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
   localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

   typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_t;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP,
                             RX_DONE, RX_BREAK} rx_state_t;

   // ---------------------------------------------------------------- TX ----
   tx_state_t            tx_state_q;
   logic [CW-1:0]        tx_cnt_q;
   logic [3:0]           tx_bit_q;
   logic [DATA_BITS-1:0] tx_shift_q;
   logic                 tx_par_q, tx_par_d;
   logic                 tx_line_q, tx_active_q, tx_done_q;

   // Odd parity is the inverted XOR of the data bits; even parity is the XOR itself.
   assign tx_par_d = (PARITY == 1) ? ~(^tx_data) : (^tx_data);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_state_q  <= TX_IDLE;
         tx_cnt_q    <= '0;
         tx_bit_q    <= '0;
         tx_shift_q  <= '0;
         tx_par_q    <= 1'b0;
         tx_line_q   <= 1'b1;
         tx_active_q <= 1'b0;
         tx_done_q   <= 1'b0;
      end else begin
         tx_done_q <= 1'b0;
         if (tx_state_q == TX_IDLE) begin
            if (tx_start) begin
               tx_shift_q  <= tx_data;
               tx_par_q    <= tx_par_d;
               tx_cnt_q    <= '0;
               tx_line_q   <= 1'b0;
               tx_active_q <= 1'b1;
               tx_state_q  <= TX_START;
            end
         end else if (tx_cnt_q != BIT_END) begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
         end else begin
            tx_cnt_q <= '0;
            case (tx_state_q)
               TX_START: begin
                  tx_line_q  <= tx_shift_q[0];
                  tx_bit_q   <= '0;
                  tx_state_q <= TX_DATA;
               end
               TX_DATA: begin
                  if (tx_bit_q != DATA_LAST) begin
                     // Bit 1 of the shifter is the next bit to go out.
                     tx_bit_q   <= tx_bit_q + 1'b1;
                     tx_shift_q <= tx_shift_q >> 1;
                     tx_line_q  <= tx_shift_q[1];
                  end else begin
                     tx_bit_q <= '0;
                     if (PARITY != 0) begin
                        tx_line_q  <= tx_par_q;
                        tx_state_q <= TX_PAR;
                     end else begin
                        tx_line_q  <= 1'b1;
                        tx_state_q <= TX_STOP;
                     end
                  end
               end
               TX_PAR: begin
                  tx_line_q  <= 1'b1;
                  tx_state_q <= TX_STOP;
               end
               TX_STOP: begin
                  if (tx_bit_q != STOP_LAST) begin
                     tx_bit_q <= tx_bit_q + 1'b1;
                  end else begin
                     // The done cycle is already IDLE, so a request in it starts the next frame.
                     tx_active_q <= 1'b0;
                     tx_done_q   <= 1'b1;
                     tx_state_q  <= TX_IDLE;
                  end
               end
               default: tx_state_q <= TX_IDLE;
            endcase
         end
      end
   end

   assign tx_active = tx_active_q;
   assign tx_done   = tx_done_q;

   // ---------------------------------------------------------------- RX ----
   logic                 rx_in;
   logic [1:0]           sync_q;
   logic                 rx_s;
   rx_state_t            rx_state_q;
   logic [CW-1:0]        rx_cnt_q;
   logic [3:0]           rx_bit_q;
   logic [DATA_BITS-1:0] rx_shift_q, rx_data_q;
   logic                 rx_par_q, rx_ferr_q;
   logic                 rx_dv_q, rx_parity_err_q, rx_frame_err_q;
   logic                 rx_par_err_d;

`ifdef UART_LOOPBACK_EN
   assign rx_in     = loopback ? tx_line_q : rx_serial;
   assign tx_serial = loopback ? 1'b1 : tx_line_q;
`else
   assign rx_in     = rx_serial;
   assign tx_serial = tx_line_q;
`endif

   assign rx_s = sync_q[1];

   assign rx_par_err_d = (PARITY != 0) &&
                         (rx_par_q != ((PARITY == 1) ? ~(^rx_shift_q) : (^rx_shift_q)));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // The synchroniser resets to the idle level so reset release is not seen as a start bit.
         sync_q          <= 2'b11;
         rx_state_q      <= RX_IDLE;
         rx_cnt_q        <= '0;
         rx_bit_q        <= '0;
         rx_shift_q      <= '0;
         rx_par_q        <= 1'b0;
         rx_ferr_q       <= 1'b0;
         rx_dv_q         <= 1'b0;
         rx_data_q       <= '0;
         rx_parity_err_q <= 1'b0;
         rx_frame_err_q  <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], rx_in};
         rx_dv_q <= 1'b0;
         case (rx_state_q)
            RX_IDLE: begin
               if (!rx_s) begin
                  rx_cnt_q   <= '0;
                  rx_state_q <= RX_START;
               end
            end
            RX_START: begin
               if (rx_cnt_q != MID_END) begin
                  rx_cnt_q <= rx_cnt_q + 1'b1;
               end else begin
                  // A high level at the start mid-point is a glitch, not a start bit.
                  rx_cnt_q   <= '0;
                  rx_bit_q   <= '0;
                  rx_state_q <= rx_s ? RX_IDLE : RX_DATA;
               end
            end
            RX_DATA, RX_PAR, RX_STOP: begin
               if (rx_cnt_q != BIT_END) begin
                  rx_cnt_q <= rx_cnt_q + 1'b1;
               end else begin
                  rx_cnt_q <= '0;
                  if (rx_state_q == RX_DATA) begin
                     rx_shift_q <= {rx_s, rx_shift_q[DATA_BITS-1:1]};
                     if (rx_bit_q != DATA_LAST) begin
                        rx_bit_q <= rx_bit_q + 1'b1;
                     end else begin
                        rx_bit_q   <= '0;
                        rx_ferr_q  <= 1'b0;
                        rx_state_q <= (PARITY != 0) ? RX_PAR : RX_STOP;
                     end
                  end else if (rx_state_q == RX_PAR) begin
                     rx_par_q   <= rx_s;
                     rx_state_q <= RX_STOP;
                  end else if (rx_bit_q != STOP_LAST) begin
                     rx_bit_q  <= rx_bit_q + 1'b1;
                     rx_ferr_q <= ~rx_s;
                  end else begin
                     // The word is delivered at the mid-point of the last stop bit.
                     rx_dv_q         <= 1'b1;
                     rx_data_q       <= rx_shift_q;
                     rx_parity_err_q <= rx_par_err_d;
                     rx_frame_err_q  <= rx_ferr_q | ~rx_s;
                     rx_state_q      <= RX_DONE;
                  end
               end
            end
            RX_DONE: begin
               // Low after a good stop bit is the next start edge; low after a bad one is a break.
               if (rx_s) begin
                  rx_state_q <= RX_IDLE;
               end else if (rx_frame_err_q) begin
                  rx_state_q <= RX_BREAK;
               end else begin
                  rx_cnt_q   <= '0;
                  rx_state_q <= RX_START;
               end
            end
            RX_BREAK: begin
               if (rx_s) rx_state_q <= RX_IDLE;
            end
            default: rx_state_q <= RX_IDLE;
         endcase
      end
   end

   assign rx_dv         = rx_dv_q;
   assign rx_data       = rx_data_q;
   assign rx_parity_err = rx_parity_err_q;
   assign rx_frame_err  = rx_frame_err_q;

endmodule

// File: tb/tb_uart_param_duplex.sv
// -----------------------------------------------------------------------------
// Testbench for uart_param_duplex. Three instances:
//   dut0 - default parameters (16, 8, none, 1)
//   dut1 - DATA_BITS=7, even parity
//   dut2 - STOP_BITS=2
// Expected received words are pushed to a per-instance queue when stimulus is
// driven and popped/compared whenever the instance pulses rx_dv.
// -----------------------------------------------------------------------------
module tb_uart_param_duplex;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   logic [2:0] rx_drv = 3'b111;
   logic       lb0 = 1'b0;
   logic       lb1 = 1'b0;

   // dut0
   logic       rx_serial0, tx_serial0, tx_start0, tx_active0, tx_done0;
   logic       rx_dv0, rx_perr0, rx_ferr0;
   logic [7:0] tx_data0, rx_data0;
   // dut1
   logic       rx_serial1, tx_serial1, tx_start1, tx_active1, tx_done1;
   logic       rx_dv1, rx_perr1, rx_ferr1;
   logic [6:0] tx_data1, rx_data1;
   // dut2
   logic       rx_serial2, tx_serial2, tx_start2, tx_active2, tx_done2;
   logic       rx_dv2, rx_perr2, rx_ferr2;
   logic [7:0] tx_data2, rx_data2;

   assign rx_serial0 = lb0 ? tx_serial0 : rx_drv[0];
   assign rx_serial1 = lb1 ? tx_serial1 : rx_drv[1];
   assign rx_serial2 = rx_drv[2];

   uart_param_duplex dut0 (
      .clk(clk), .reset(reset), .rx_serial(rx_serial0), .tx_serial(tx_serial0),
      .tx_start(tx_start0), .tx_data(tx_data0), .tx_active(tx_active0), .tx_done(tx_done0),
      .rx_dv(rx_dv0), .rx_data(rx_data0), .rx_parity_err(rx_perr0), .rx_frame_err(rx_ferr0)
   );

   uart_param_duplex #(.CLKS_PER_BIT(16), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) dut1 (
      .clk(clk), .reset(reset), .rx_serial(rx_serial1), .tx_serial(tx_serial1),
      .tx_start(tx_start1), .tx_data(tx_data1), .tx_active(tx_active1), .tx_done(tx_done1),
      .rx_dv(rx_dv1), .rx_data(rx_data1), .rx_parity_err(rx_perr1), .rx_frame_err(rx_ferr1)
   );

   uart_param_duplex #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) dut2 (
      .clk(clk), .reset(reset), .rx_serial(rx_serial2), .tx_serial(tx_serial2),
      .tx_start(tx_start2), .tx_data(tx_data2), .tx_active(tx_active2), .tx_done(tx_done2),
      .rx_dv(rx_dv2), .rx_data(rx_data2), .rx_parity_err(rx_perr2), .rx_frame_err(rx_ferr2)
   );

   // Scoreboards hold {frame_err, parity_err, data[8:0]}.
   logic [31:0] q0[$];
   logic [31:0] q1[$];
   logic [31:0] q2[$];
   int dv_cnt0 = 0, dv_cnt1 = 0, dv_cnt2 = 0, done_cnt0 = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] pack(input logic fe, input logic pe, input logic [8:0] d);
      return {21'b0, fe, pe, d};
   endfunction

   // RX monitors / scoreboard consumers
   always @(negedge clk) begin
      if (!reset) begin
         if (tx_done0) done_cnt0++;
         if (rx_dv0) begin
            dv_cnt0++;
            if (q0.size() == 0) check_eq("rx0_dv_unexpected", 32'(rx_dv0), 32'd0);
            else check_eq("rx0_word", pack(rx_ferr0, rx_perr0, {1'b0, rx_data0}), q0.pop_front());
            $display("rx0 word 0x%0h perr=%0b ferr=%0b", rx_data0, rx_perr0, rx_ferr0);
         end
         if (rx_dv1) begin
            dv_cnt1++;
            if (q1.size() == 0) check_eq("rx1_dv_unexpected", 32'(rx_dv1), 32'd0);
            else check_eq("rx1_word", pack(rx_ferr1, rx_perr1, {2'b0, rx_data1}), q1.pop_front());
            $display("rx1 word 0x%0h perr=%0b ferr=%0b", rx_data1, rx_perr1, rx_ferr1);
         end
         if (rx_dv2) begin
            dv_cnt2++;
            if (q2.size() == 0) check_eq("rx2_dv_unexpected", 32'(rx_dv2), 32'd0);
            else check_eq("rx2_word", pack(rx_ferr2, rx_perr2, {1'b0, rx_data2}), q2.pop_front());
            $display("rx2 word 0x%0h perr=%0b ferr=%0b", rx_data2, rx_perr2, rx_ferr2);
         end
      end
   end

   // Drive n serial bits (LSB first) on one bench-driven RX line; the line keeps the last bit.
   task automatic drive_line(input int sel, input logic [31:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         rx_drv[sel] = bits[i];
         repeat (16) @(negedge clk);
      end
   endtask

   // Send one word on dut0 starting at the current negedge; returns on the tx_done negedge.
   task automatic tx_frame0(input logic [7:0] d);
      int n;
      tx_data0  = d;
      tx_start0 = 1'b1;
      q0.push_back(pack(1'b0, 1'b0, {1'b0, d}));
      @(negedge clk);
      tx_start0 = 1'b0;
      n = 1;
      while (!tx_done0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      check_eq("tx0_frame_len", 32'(n), 32'd161);
      $display("tx0 sent 0x%0h", d);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached before end of test");
      $fatal(1);
   end

   logic [7:0] exp_byte;
   logic       exp_line;
   int         base_done, base_dv, n;
   logic [7:0] msg [5] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};

   initial begin
      tx_start0 = 1'b0; tx_data0 = '0;
      tx_start1 = 1'b0; tx_data1 = '0;
      tx_start2 = 1'b0; tx_data2 = '0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("rst_tx_serial", 32'(tx_serial0), 32'd1);
      check_eq("rst_tx_active", 32'(tx_active0), 32'd0);
      check_eq("rst_tx_done", 32'(tx_done0), 32'd0);
      check_eq("rst_rx_dv", 32'(rx_dv0), 32'd0);
      check_eq("rst_rx_data", 32'(rx_data0), 32'd0);
      check_eq("rst_rx_flags", 32'({rx_perr0, rx_ferr0}), 32'd0);
      reset = 1'b0;
      repeat (3) @(negedge clk);

      // ---- exact TX waveform for 0x48, with a busy tx_start at N+50
      exp_byte  = 8'h48;
      base_done = done_cnt0;
      tx_data0  = 8'h48;
      tx_start0 = 1'b1;
      for (int k = 1; k <= 161; k++) begin
         @(negedge clk);
         if (k == 1) tx_start0 = 1'b0;
         if (k == 49) begin tx_start0 = 1'b1; tx_data0 = 8'hFF; end
         if (k == 50) tx_start0 = 1'b0;
         if (k <= 16)       exp_line = 1'b0;
         else if (k <= 144) exp_line = exp_byte[(k - 17) / 16];
         else               exp_line = 1'b1;
         check_eq($sformatf("tx_line_k%0d", k), 32'(tx_serial0), 32'(exp_line));
         check_eq($sformatf("tx_active_k%0d", k), 32'(tx_active0), 32'(k <= 160));
         check_eq($sformatf("tx_done_k%0d", k), 32'(tx_done0), 32'(k == 161));
      end
      repeat (200) @(negedge clk);
      check_eq("busy_start_done_count", 32'(done_cnt0 - base_done), 32'd1);
      check_eq("busy_start_not_queued", 32'(tx_active0), 32'd0);
      $display("tx0 waveform 0x48 done");

      // ---- loopback, back-to-back frames
      lb0 = 1'b1;
      repeat (5) @(negedge clk);
      base_dv = dv_cnt0;
      for (int i = 0; i < 5; i++) tx_frame0(msg[i]);
      repeat (50) @(negedge clk);
      check_eq("b2b_rx_count", 32'(dv_cnt0 - base_dv), 32'd5);
      check_eq("b2b_queue_empty", 32'(q0.size()), 32'd0);
      lb0 = 1'b0;
      repeat (5) @(negedge clk);

      // ---- dut1: 7 data bits, even parity
      lb1 = 1'b1;
      repeat (5) @(negedge clk);
      tx_data1  = 7'h41;
      tx_start1 = 1'b1;
      q1.push_back(pack(1'b0, 1'b0, 9'h041));
      for (int k = 1; k <= 152; k++) begin
         @(negedge clk);
         if (k == 1) tx_start1 = 1'b0;
         if (k == 8)   check_eq("tx1_start_bit", 32'(tx_serial1), 32'd0);
         if (k == 24)  check_eq("tx1_data_bit0", 32'(tx_serial1), 32'd1);
         if (k == 40)  check_eq("tx1_data_bit1", 32'(tx_serial1), 32'd0);
         if (k == 136) check_eq("tx1_parity_bit", 32'(tx_serial1), 32'd0);
         if (k == 152) check_eq("tx1_stop_bit", 32'(tx_serial1), 32'd1);
      end
      n = 152;
      while (!tx_done1 && n < 400) begin
         @(negedge clk);
         n++;
      end
      check_eq("tx1_frame_len", 32'(n), 32'd161);
      repeat (30) @(negedge clk);
      lb1 = 1'b0;
      repeat (5) @(negedge clk);
      q1.push_back(pack(1'b0, 1'b1, 9'h041));
      drive_line(1, {1'b1, 1'b1, 7'h41, 1'b0}, 10);
      repeat (30) @(negedge clk);
      check_eq("rx1_count", 32'(dv_cnt1), 32'd2);
      check_eq("rx1_queue_empty", 32'(q1.size()), 32'd0);

      // ---- dut2: second stop bit low, then a long low (break)
      q2.push_back(pack(1'b1, 1'b0, 9'h0A5));
      drive_line(2, {1'b0, 1'b1, 8'hA5, 1'b0}, 11);
      repeat (100) @(negedge clk);
      check_eq("break_single_dv", 32'(dv_cnt2), 32'd1);
      rx_drv[2] = 1'b1;
      repeat (40) @(negedge clk);
      check_eq("break_no_extra_dv", 32'(dv_cnt2), 32'd1);
      q2.push_back(pack(1'b0, 1'b0, 9'h03C));
      drive_line(2, {1'b1, 1'b1, 8'h3C, 1'b0}, 11);
      repeat (30) @(negedge clk);
      check_eq("rx2_count", 32'(dv_cnt2), 32'd2);
      check_eq("rx2_queue_empty", 32'(q2.size()), 32'd0);

      // ---- 4-cycle low glitch on dut0
      base_dv = dv_cnt0;
      rx_drv[0] = 1'b0;
      repeat (4) @(negedge clk);
      rx_drv[0] = 1'b1;
      repeat (60) @(negedge clk);
      check_eq("glitch_no_dv", 32'(dv_cnt0), 32'(base_dv));

      // ---- reset mid-TX at N+80
      base_done = done_cnt0;
      tx_data0  = 8'h3C;
      tx_start0 = 1'b1;
      for (int k = 1; k <= 80; k++) begin
         @(negedge clk);
         if (k == 1) tx_start0 = 1'b0;
      end
      reset = 1'b1;
      #1;
      check_eq("rst_mid_tx_serial", 32'(tx_serial0), 32'd1);
      check_eq("rst_mid_tx_active", 32'(tx_active0), 32'd0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);

      // ---- reset mid-RX
      drive_line(0, {8'h3C, 1'b0}, 5);
      reset = 1'b1;
      #1;
      check_eq("rst_mid_rx_dv", 32'(rx_dv0), 32'd0);
      check_eq("rst_mid_rx_data", 32'(rx_data0), 32'd0);
      rx_drv[0] = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (200) @(negedge clk);
      check_eq("rst_no_tx_done", 32'(done_cnt0), 32'(base_done));
      check_eq("rst_no_rx_dv", 32'(dv_cnt0), 32'(base_dv));

      // ---- fresh frame after reset
      lb0 = 1'b1;
      repeat (5) @(negedge clk);
      tx_frame0(8'h3C);
      repeat (40) @(negedge clk);
      check_eq("post_rst_rx_count", 32'(dv_cnt0), 32'(base_dv + 1));
      check_eq("post_rst_queue_empty", 32'(q0.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
